// File: rtl/drum_audio_bridge.sv
// Paces the drum mesh solver one time-step per audio sample, converts the
// 18-bit center-node amplitude to a saturated 16-bit sample and hands it off.
module drum_audio_bridge #(
  parameter int GAIN_SHIFT = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        strike,
  output logic        drum_init,
  output logic        step_req,
  input  logic        step_done,
  input  logic [17:0] drum_sample,
  output logic [15:0] audio_data,
  output logic        audio_valid,
  input  logic        audio_ready,
  output logic [31:0] sample_count,
  output logic        timeout_err
);
  localparam int EXT_W = 18 + GAIN_SHIFT;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic signed [EXT_W-1:0] SAT_HI  = EXT_W'(131071);
  localparam logic signed [EXT_W-1:0] SAT_LO  = EXT_W'(-131072);
  localparam logic        [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_REQ, S_WAIT, S_SEND} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_pend, w_pend_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic              r_init, w_init_nxt;
  logic              r_req, w_req_nxt;
  logic              r_valid, w_valid_nxt;
  logic [15:0]       r_data, w_data_nxt;
  logic [31:0]       r_count, w_count_nxt;
  logic              r_tout, w_tout_nxt;

  logic signed [17:0]      w_smp;
  logic signed [EXT_W-1:0] w_ext;
  logic [15:0]             w_conv;

  // Widened before shifting so the gain can never wrap; clamp, then drop 2 LSBs (floor).
  assign w_smp = drum_sample;
  assign w_ext = EXT_W'(w_smp) <<< GAIN_SHIFT;

  always_comb begin
    if (w_ext > SAT_HI)      w_conv = 16'h7FFF;
    else if (w_ext < SAT_LO) w_conv = 16'h8000;
    else                     w_conv = w_ext[17:2];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend | strike;
    w_cnt_inc   = r_cnt + 1'b1;
    w_cnt_nxt   = r_cnt;
    w_init_nxt  = 1'b0;
    w_req_nxt   = 1'b0;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    w_tout_nxt  = r_tout;
    case (r_state)
      S_IDLE: if (enable) begin
        if (r_pend) begin
          // a strike landing on the same edge is a fresh hit and stays pending
          w_state_nxt = S_INIT;
          w_init_nxt  = 1'b1;
          w_pend_nxt  = strike;
        end else begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
        end
      end
      S_INIT: w_state_nxt = S_IDLE;
      S_REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (step_done) begin
          w_data_nxt  = w_conv;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_SEND;
        end else if (w_cnt_inc == TO_LAST) begin
          w_tout_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: if (audio_ready) begin
        w_valid_nxt = 1'b0;
        w_count_nxt = r_count + 32'd1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_init  <= 1'b0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
      r_tout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_init  <= w_init_nxt;
      r_req   <= w_req_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
      r_tout  <= w_tout_nxt;
    end
  end

  assign drum_init    = r_init;
  assign step_req     = r_req;
  assign audio_data   = r_data;
  assign audio_valid  = r_valid;
  assign sample_count = r_count;
  assign timeout_err  = r_tout;
endmodule

// File: tb/tb_drum_audio_bridge.sv
// Bench for drum_audio_bridge: two gain settings driven in lockstep by a solver
// model, with a sample scoreboard computed from the conversion arithmetic.
module tb_drum_audio_bridge;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, strike = 1'b0, step_done = 1'b0, audio_ready = 1'b0;
  logic [17:0] drum_sample = '0;
  logic        d1_init, d1_req, d1_valid, d1_tout, d3_init, d3_req, d3_valid, d3_tout;
  logic [15:0] d1_data, d3_data;
  logic [31:0] d1_count, d3_count;

  always #5 clk = ~clk;

  drum_audio_bridge #(.GAIN_SHIFT(1), .TIMEOUT(16)) u_g1 (
    .clk(clk), .reset(reset), .enable(enable), .strike(strike),
    .drum_init(d1_init), .step_req(d1_req), .step_done(step_done),
    .drum_sample(drum_sample), .audio_data(d1_data), .audio_valid(d1_valid),
    .audio_ready(audio_ready), .sample_count(d1_count), .timeout_err(d1_tout)
  );

  drum_audio_bridge #(.GAIN_SHIFT(3), .TIMEOUT(16)) u_g3 (
    .clk(clk), .reset(reset), .enable(enable), .strike(strike),
    .drum_init(d3_init), .step_req(d3_req), .step_done(step_done),
    .drum_sample(drum_sample), .audio_data(d3_data), .audio_valid(d3_valid),
    .audio_ready(audio_ready), .sample_count(d3_count), .timeout_err(d3_tout)
  );

  int checks = 0, failures = 0;
  int cyc = 0, exp_count = 0, rem = 0, lat = 1, rdy_mode = 0;
  int n_req = 0, n_init = 0, last_acc_cyc = 0;
  bit solver_en = 1'b1, lat_rand = 1'b0, fixed_en = 1'b0, spur = 1'b0;
  bit done_prev = 1'b0, pv_valid = 1'b0, p_ready = 1'b0;
  logic [15:0] pv_d1 = '0, pv_d3 = '0, last_acc1 = '0, last_acc3 = '0;
  logic [17:0] fixed_val = '0;
  logic [15:0] q1[$], q3[$], acc1[$], acc3[$];
  logic [17:0] sq[$];
  int rq[$], iq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference conversion: scale by 2^g, clamp to 18-bit signed, floor-divide by 4.
  function automatic logic [15:0] conv(input logic [17:0] x, input int g);
    int v;
    v = int'($signed(x)) * (1 << g);
    if (v > 131071)  v = 131071;
    if (v < -131072) v = -131072;
    v = v >>> 2;
    return v[15:0];
  endfunction

  task automatic tick();
    logic [17:0] smp;
    int r;
    @(negedge clk);
    cyc++;
    if (done_prev) chk("valid_after_done", 32'(d1_valid), 32'd1);
    if (pv_valid && !p_ready) begin
      chk("hold_valid", 32'(d1_valid), 32'd1);
      chk("hold_data_g1", 32'(d1_data), 32'(pv_d1));
      chk("hold_data_g3", 32'(d3_data), 32'(pv_d3));
    end
    chk("count_g1", d1_count, 32'(exp_count));
    chk("count_g3", d3_count, 32'(exp_count));
    if (d1_req) begin n_req++; rq.push_back(cyc); end
    if (d1_init) begin n_init++; iq.push_back(cyc); end
    done_prev = 1'b0;
    step_done = 1'b0;
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        if (fixed_en) smp = fixed_val;
        else if (sq.size() > 0) begin smp = sq[0]; sq.delete(0); end
        else begin
          r = int'($urandom_range(0, 7));
          smp = 18'($urandom());
          if (r == 0) smp = 18'h1FFFF;
          else if (r == 1) smp = 18'h20000;
        end
        drum_sample = smp;
        step_done = 1'b1;
        done_prev = 1'b1;
        q1.push_back(conv(smp, 1));
        q3.push_back(conv(smp, 3));
      end
    end else if (spur) begin
      step_done = 1'b1;
      drum_sample = 18'($urandom());
    end
    if (d1_req && solver_en) rem = lat_rand ? int'($urandom_range(1, 4)) : lat;
    case (rdy_mode)
      0: audio_ready = 1'b0;
      1: audio_ready = 1'b1;
      default: audio_ready = ($urandom_range(0, 9) < 7);
    endcase
    if (d1_valid && audio_ready) begin
      chk("accept_expected", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        chk("data_g1", 32'(d1_data), 32'(q1[0]));
        chk("data_g3", 32'(d3_data), 32'(q3[0]));
        q1.delete(0);
        q3.delete(0);
      end
      acc1.push_back(d1_data);
      acc3.push_back(d3_data);
      last_acc1 = d1_data;
      last_acc3 = d3_data;
      last_acc_cyc = cyc;
      exp_count++;
    end
    pv_valid = d1_valid;
    p_ready  = audio_ready;
    pv_d1    = d1_data;
    pv_d3    = d3_data;
  endtask

  initial begin
    int base_cnt, base_req, base_acc, base_init, ic, n_acc0;
    bit ok;
    // reset held 3 cycles, enable low
    #2 reset = 1'b0;
    repeat (3) tick();
    chk("rst_init", 32'(d1_init), 32'd0);
    chk("rst_req", 32'(d1_req), 32'd0);
    chk("rst_valid", 32'(d1_valid), 32'd0);
    chk("rst_data", 32'(d1_data), 32'd0);
    chk("rst_count", d1_count, 32'd0);
    chk("rst_tout", 32'(d1_tout), 32'd0);
    chk("rst_g3_ctl", 32'({d3_init, d3_req, d3_valid, d3_tout}), 32'd0);
    chk("rst_g3_data", 32'(d3_data), 32'd0);
    reset = 1'b1;
    // idle with enable low; a strike here must wait for enable
    for (int i = 0; i < 20; i++) begin
      strike = (i == 5);
      tick();
    end
    strike = 1'b0;
    chk("idle_no_req", 32'(n_req), 32'd0);
    chk("idle_no_init", 32'(n_init), 32'd0);
    chk("idle_g3_ctl", 32'({d3_init, d3_req, d3_valid}), 32'd0);

    // fixed sample, 1-cycle solver, ready high
    rq.delete(); iq.delete();
    fixed_en = 1'b1; fixed_val = 18'h08000; lat = 1; rdy_mode = 1; enable = 1'b1;
    for (int i = 0; i < 200 && exp_count < 10; i++) tick();
    tick();
    fixed_en = 1'b0;
    chk("count10_g1", d1_count, 32'd10);
    chk("count10_g3", d3_count, 32'd10);
    chk("gain1_8000", 32'(last_acc1), 32'h4000);
    chk("gain3_8000", 32'(last_acc3), 32'h7FFF);
    chk("enable_init_once", 32'(n_init), 32'd1);
    ok = (iq.size() > 0) && (rq.size() > 0);
    chk("init_then_req_gap", 32'(ok ? rq[0] - iq[0] : -1), 32'd2);
    for (int i = 1; i < rq.size(); i++) chk("req_period", 32'(rq[i] - rq[i-1]), 32'd4);

    // directed conversion boundaries
    acc1.delete(); acc3.delete();
    sq = '{18'h38000, 18'h00004, 18'h1FFFF, 18'h20000, 18'h3FFFF};
    for (int i = 0; i < 100 && acc3.size() < 5; i++) tick();
    chk("g3_neg32768", 32'(acc3[0]), 32'h8000);
    chk("g3_four", 32'(acc3[1]), 32'h0008);
    chk("g1_neg32768", 32'(acc1[0]), 32'hC000);
    chk("g1_four", 32'(acc1[1]), 32'h0002);
    chk("g3_posmax", 32'(acc3[2]), 32'h7FFF);
    chk("g1_posmax", 32'(acc1[2]), 32'h7FFF);
    chk("g3_negmax", 32'(acc3[3]), 32'h8000);
    chk("g1_negmax", 32'(acc1[3]), 32'h8000);
    chk("g1_minus1_floor", 32'(acc1[4]), 32'hFFFF);
    chk("g3_minus1_floor", 32'(acc3[4]), 32'hFFFE);

    // random data, latency and backpressure
    n_acc0 = exp_count;
    lat_rand = 1'b1; rdy_mode = 2;
    repeat (400) tick();
    lat_rand = 1'b0; lat = 1; rdy_mode = 1;
    repeat (20) tick();
    chk("random_progress", 32'(exp_count - n_acc0 >= 20), 32'd1);

    // 50-cycle stall in SEND with spurious step_done
    rdy_mode = 0;
    for (int i = 0; i < 30 && !d1_valid; i++) tick();
    chk("stall_reach_send", 32'(d1_valid), 32'd1);
    base_cnt = exp_count; base_req = n_req;
    for (int i = 0; i < 50; i++) begin
      spur = i[0];
      tick();
    end
    spur = 1'b0;
    chk("stall_valid_g1", 32'(d1_valid), 32'd1);
    chk("stall_valid_g3", 32'(d3_valid), 32'd1);
    chk("stall_no_req", 32'(n_req - base_req), 32'd0);
    chk("stall_count", d1_count, 32'(base_cnt));
    rdy_mode = 1;
    tick();
    rdy_mode = 0;
    repeat (6) tick();
    chk("one_accept", d1_count, 32'(base_cnt + 1));

    // strike during WAIT
    rdy_mode = 1; lat = 3;
    for (int i = 0; i < 30 && !d1_req; i++) tick();
    chk("strike_req_seen", 32'(d1_req), 32'd1);
    tick();
    base_acc = exp_count; base_init = n_init;
    strike = 1'b1;
    tick();
    strike = 1'b0;
    for (int i = 0; i < 30 && n_init == base_init; i++) tick();
    chk("strike_one_init", 32'(n_init - base_init), 32'd1);
    chk("strike_sample_sent", 32'(exp_count - base_acc), 32'd1);
    ic = (iq.size() > 0) ? iq[$] : 0;
    chk("accept_before_init", 32'(last_acc_cyc < ic), 32'd1);
    for (int i = 0; i < 10 && !d1_req; i++) tick();
    chk("init_to_req", 32'(rq[$] - ic), 32'd2);
    repeat (8) tick();
    chk("no_extra_init", 32'(n_init - base_init), 32'd1);

    // silent solver -> timeout
    solver_en = 1'b0;
    tick();
    for (int i = 0; i < 30 && !d1_req; i++) tick();
    chk("to_req_seen", 32'(d1_req), 32'd1);
    chk("to_before", 32'(d1_tout), 32'd0);
    repeat (15) tick();
    chk("to_at15", 32'(d1_tout), 32'd0);
    tick();
    chk("to_at16_g1", 32'(d1_tout), 32'd1);
    chk("to_at16_g3", 32'(d3_tout), 32'd1);
    chk("to_no_sample", 32'(d1_valid), 32'd0);
    tick();
    chk("to_rerequest", 32'(d1_req), 32'd1);
    solver_en = 1'b1;
    repeat (40) tick();
    chk("to_sticky_g1", 32'(d1_tout), 32'd1);
    chk("to_sticky_g3", 32'(d3_tout), 32'd1);

    // asynchronous reset while holding a sample
    rdy_mode = 0;
    for (int i = 0; i < 40 && !d1_valid; i++) tick();
    chk("ar_reach_send", 32'(d1_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("ar_valid_g1", 32'(d1_valid), 32'd0);
    chk("ar_valid_g3", 32'(d3_valid), 32'd0);
    chk("ar_count", d1_count, 32'd0);
    chk("ar_tout", 32'(d1_tout), 32'd0);
    q1.delete(); q3.delete();
    exp_count = 0; rem = 0; pv_valid = 1'b0; done_prev = 1'b0;
    step_done = 1'b0; enable = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    base_req = n_req;
    repeat (5) tick();
    chk("ar_idle_no_req", 32'(n_req - base_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
